// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and Status/Cause field layout
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_TI   = 30;

  // IM[15:8], EXL and IE are the only software-visible Status bits
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - pipeline-facing CP0 register access and exception commit bus
interface cp0_exc_ctrl_if;
  logic [4:0]  addrR;
  logic [2:0]  selR;
  logic [4:0]  addrW;
  logic [2:0]  selW;
  logic [31:0] din;
  logic        cp0Write;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] dout;

  modport master (
    output addrR, selR, addrW, selW, din, cp0Write,
    output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
    input  dout
  );

  modport slave (
    input  addrR, selR, addrW, selW, din, cp0Write,
    input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
    output dout
  );
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with clock divider and sticky timer interrupt
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] phase;
  logic          tick;

  assign tick = (phase == PHASE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= din;
        phase <= '0;
      end else begin
        phase <= tick ? '0 : phase + PW'(1);
        if (tick) count <= count + 32'd1;
      end
      if (compare_we) compare <= din;
      // A Compare write acknowledges the interrupt even if a match lands this cycle
      if (compare_we)
        ti <= 1'b0;
      else if (tick && !count_we && (count == compare))
        ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 with exception entry, ERET, Count/Compare timer and interrupts
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cp0_exc_ctrl_if.slave         bus,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [31:0]           epc,
  output logic                  int_req,
  output logic                  exl
);

  logic [31:0] status_q, epc_q, badvaddr_q, count, compare, cause;
  logic [4:0]  code_q;
  logic [1:0]  swip_q;
  logic [5:0]  hwip_q, hw_ext;
  logic [7:0]  ip;
  logic        bd_q, ti, wr_ok, reg_we;

  // An exception swallows a coincident MTC0 completely; ERET only shadows the exception-side registers
  assign wr_ok  = bus.cp0Write && (bus.selW == 3'd0) && !bus.exc_valid;
  assign reg_we = wr_ok && !bus.eret;

  always_comb begin
    hw_ext = '0;
    hw_ext[NUM_HW_INT-1:0] = hw_int;
  end

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (wr_ok && (bus.addrW == CP0_COUNT)),
    .compare_we (wr_ok && (bus.addrW == CP0_COMPARE)),
    .din        (bus.din),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      badvaddr_q <= '0;
      code_q     <= '0;
      swip_q     <= '0;
      hwip_q     <= '0;
      bd_q       <= 1'b0;
    end else begin
      hwip_q <= hw_ext;
      if (bus.exc_valid) begin
        code_q <= bus.exc_code;
        if (!status_q[STATUS_EXL]) begin
          epc_q <= bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
          bd_q  <= bus.exc_bd;
          status_q[STATUS_EXL] <= 1'b1;
        end
        if (is_addr_exc(bus.exc_code)) badvaddr_q <= bus.exc_badvaddr;
      end else if (bus.eret) begin
        status_q[STATUS_EXL] <= 1'b0;
      end else if (reg_we) begin
        case (bus.addrW)
          CP0_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (bus.din & STATUS_WMASK);
          CP0_CAUSE:  swip_q   <= bus.din[9:8];
          CP0_EPC:    epc_q    <= bus.din;
          default:    ;
        endcase
      end
    end
  end

  assign ip    = {hwip_q[5] | ti, hwip_q[4:0], swip_q};
  assign cause = {bd_q, ti, 14'd0, ip, 1'b0, code_q, 2'b00};

  always_comb begin
    bus.dout = '0;
    if (bus.selR == 3'd0) begin
      case (bus.addrR)
        CP0_BADVADDR: bus.dout = badvaddr_q;
        CP0_COUNT:    bus.dout = count;
        CP0_COMPARE:  bus.dout = compare;
        CP0_STATUS:   bus.dout = status_q;
        CP0_CAUSE:    bus.dout = cause;
        CP0_EPC:      bus.dout = epc_q;
        default:      bus.dout = '0;
      endcase
    end
  end

  assign epc     = epc_q;
  assign exl     = status_q[STATUS_EXL];
  assign int_req = status_q[STATUS_IE] & ~status_q[STATUS_EXL] & |(ip & status_q[15:8]);

endmodule
